// File: rtl/l2_port_arbiter.sv
// ---------------------------------------------------------------------------
// l2_port_arbiter
//
// Purpose:
//   Arbitrates NUM_PORTS L1 cache ports (index 0 = icache, 1 = dcache, higher
//   indices for future clients) onto one shared line-wide downstream port
//   (L2 cache or physical memory). Only one transaction is outstanding at a
//   time. The winning request is latched on grant and driven unchanged
//   downstream until the downstream response arrives. The response is then
//   returned to the granted port alone, as a one-cycle done pulse.
//
//   Arbitration is round-robin when RR_MODE = 1. The search starts at rr_ptr
//   and wraps from NUM_PORTS-1 to 0. When RR_MODE = 0, the lowest active
//   index wins.
//
// Parameters:
//   NUM_PORTS   number of requesting ports (>= 2)
//   ADDR_WIDTH  line address width
//   LINE_WIDTH  cache line width
//   RR_MODE     1: round-robin, 0: fixed priority (lowest index wins)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   req_read    in   [NUM_PORTS]             per-port line read request
//   req_write   in   [NUM_PORTS]             per-port line write request
//                                            (read+write together = write)
//   req_addr    in   [NUM_PORTS*ADDR_WIDTH]  per-port line address
//   req_wdata   in   [NUM_PORTS*LINE_WIDTH]  per-port write line
//   req_rdata   out  [LINE_WIDTH]            read line, shared by all ports
//   req_resp    out  [NUM_PORTS]             one-hot done pulse, one cycle
//   down_read   out  downstream read strobe
//   down_write  out  downstream write strobe
//   down_addr   out  [ADDR_WIDTH]            downstream address
//   down_wdata  out  [LINE_WIDTH]            downstream write line
//   down_rdata  in   [LINE_WIDTH]            downstream read line
//   down_resp   in   downstream done, one cycle
// ---------------------------------------------------------------------------
module l2_port_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128,
    parameter int RR_MODE    = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
    output logic [LINE_WIDTH-1:0]            req_rdata,
    output logic [NUM_PORTS-1:0]             req_resp,
    output logic                             down_read,
    output logic                             down_write,
    output logic [ADDR_WIDTH-1:0]            down_addr,
    output logic [LINE_WIDTH-1:0]            down_wdata,
    input  logic [LINE_WIDTH-1:0]            down_rdata,
    input  logic                             down_resp
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                 state_q,      state_d;
    logic [PTR_W-1:0]       grant_q,      grant_d;
    logic [PTR_W-1:0]       rr_ptr_q,     rr_ptr_d;
    logic                   write_q,      write_d;
    logic [ADDR_WIDTH-1:0]  addr_q,       addr_d;
    logic [LINE_WIDTH-1:0]  wdata_q,      wdata_d;
    logic [LINE_WIDTH-1:0]  rdata_q,      rdata_d;
    logic [NUM_PORTS-1:0]   resp_q,       resp_d;
    logic                   down_read_q,  down_read_d;
    logic                   down_write_q, down_write_d;

    logic [NUM_PORTS-1:0]   active_s;
    logic [PTR_W-1:0]       search_base_s;
    logic [PTR_W:0]         pick_s;
    logic                   pick_found_s;
    logic [PTR_W-1:0]       pick_idx_s;
    logic [ADDR_WIDTH-1:0]  sel_addr_s;
    logic [LINE_WIDTH-1:0]  sel_wdata_s;
    logic                   sel_write_s;
    logic [PTR_W-1:0]       grant_next_ptr_s;

    // Returns {found, index} of the first active port at or after base.
    // The search wraps modulo NUM_PORTS, so it also works when NUM_PORTS is
    // not a power of two.
    function automatic logic [PTR_W:0] pick_port(
        input logic [NUM_PORTS-1:0] active,
        input logic [PTR_W-1:0]     base
    );
        logic             found;
        logic [PTR_W-1:0] win;
        int               idx;
        found = 1'b0;
        win   = {PTR_W{1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(base) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end else begin
                idx = idx;
            end
            if (!found && active[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = idx[PTR_W-1:0];
            end else begin
                found = found;
            end
        end
        return {found, win};
    endfunction

    // A port is active when it asks for a read or a write.
    // When both are set, the port is treated as a write.
    assign active_s      = req_read | req_write;
    assign search_base_s = (RR_MODE != 0) ? rr_ptr_q : {PTR_W{1'b0}};
    assign pick_s        = pick_port(active_s, search_base_s);
    assign pick_found_s  = pick_s[PTR_W];
    assign pick_idx_s    = pick_s[PTR_W-1:0];

    // The pointer advances past the port just served, wrapping at NUM_PORTS.
    assign grant_next_ptr_s = (grant_q == PTR_W'(NUM_PORTS - 1)) ? {PTR_W{1'b0}}
                                                                 : grant_q + PTR_W'(1);

    // Mux the winning port's operation, address and write line.
    always_comb begin
        sel_addr_s  = {ADDR_WIDTH{1'b0}};
        sel_wdata_s = {LINE_WIDTH{1'b0}};
        sel_write_s = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (pick_idx_s == PTR_W'(p)) begin
                sel_addr_s  = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata_s = req_wdata[p*LINE_WIDTH +: LINE_WIDTH];
                sel_write_s = req_write[p];
            end else begin
                sel_write_s = sel_write_s;
            end
        end
    end

    // Next-state logic and next values of all registered outputs.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_d = ST_BUSY;
                    grant_d = pick_idx_s;
                    write_d = sel_write_s;
                    addr_d  = sel_addr_s;
                    wdata_d = sel_wdata_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Request inputs are ignored here. The latched transaction runs to completion.
                if (down_resp) begin
                    state_d  = ST_RESP;
                    rr_ptr_d = grant_next_ptr_s;
                    if (!write_q) begin
                        rdata_d = down_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are derived from the next state, so they become registers
        // and take effect in the same cycle as the state itself.
        down_read_d  = (state_d == ST_BUSY) && !write_d;
        down_write_d = (state_d == ST_BUSY) &&  write_d;
        for (int p = 0; p < NUM_PORTS; p++) begin
            resp_d[p] = (state_d == ST_RESP) && (grant_d == PTR_W'(p));
        end
    end

    // State and datapath registers. Reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= {PTR_W{1'b0}};
            rr_ptr_q     <= {PTR_W{1'b0}};
            write_q      <= 1'b0;
            addr_q       <= {ADDR_WIDTH{1'b0}};
            wdata_q      <= {LINE_WIDTH{1'b0}};
            rdata_q      <= {LINE_WIDTH{1'b0}};
            resp_q       <= {NUM_PORTS{1'b0}};
            down_read_q  <= 1'b0;
            down_write_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            resp_q       <= resp_d;
            down_read_q  <= down_read_d;
            down_write_q <= down_write_d;
        end
    end

    assign req_rdata  = rdata_q;
    assign req_resp   = resp_q;
    assign down_read  = down_read_q;
    assign down_write = down_write_q;
    assign down_addr  = addr_q;
    assign down_wdata = wdata_q;

endmodule
